tri_mux_arbiter: RTL and testbench
==================================

Name: tri_mux_arbiter

Overview:
Round-robin arbiter that shares one three-input select mux, and the adder datapath behind it, between three requesters. It produces the mux's 2-bit select plus a one-hot grant. Grants are held while the owner keeps its request high. A hold-time limit and a programmable dead-time gap keep one requester from starving the others and give the datapath settle cycles between owners.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles a grant may stay asserted; 0 disables the limit
IDLE_GAP, 1, dead cycles (gnt all-zero) inserted after each grant ends; legal range 0..3

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  3  request per requester; held high for the whole transaction, dropped to release
gnt  output  3  one-hot grant; at most one bit high
sel  output  2  mux select: 2'b00/01/10 = requester 0/1/2; 2'b11 never driven
busy  output  1  high whenever state != IDLE
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n), all state cleared immediately on assertion, independent of clk.
- Reset values: gnt=3'b000, sel=2'b00, busy=0, timeout=0, state=IDLE, ptr=0, mask=3'b000, hold_cnt=0, gap_cnt=0.
- All outputs registered; no combinational path from req to any output.
- States: IDLE, GRANT, GAP.
- Eligibility: eligible[i] = req[i] & ~mask[i].
- IDLE: if any eligible, the winner is the first eligible in order ptr, ptr+1, ptr+2 (mod 3).
  - Next edge: gnt[w]=1, sel=w, ptr=(w+1) mod 3, hold_cnt=1, go to GRANT.
  - Latency: req sampled high at edge N yields gnt high after edge N (one cycle).
  - If nothing is eligible, stay in IDLE.
- GRANT, release: if req[owner]=0 at an edge, gnt clears at that edge. Go to GAP with gap_cnt=0, or to IDLE directly when IDLE_GAP=0.
- GRANT, hold limit: if MAX_HOLD!=0, req[owner]=1 and hold_cnt==MAX_HOLD at an edge:
  - gnt clears, timeout=1 for exactly one cycle, mask[owner]=1, go to GAP (or IDLE if IDLE_GAP=0).
  - gnt is therefore high for exactly MAX_HOLD cycles.
- GRANT, otherwise: hold_cnt increments, saturating at MAX_HOLD. Width is clog2(MAX_HOLD+1), minimum 1 bit.
- GAP: gnt=0; gap_cnt increments each cycle; after IDLE_GAP cycles go to IDLE.
- Minimum spacing from gnt falling to the next gnt rising is IDLE_GAP+1 cycles, because IDLE always spends one arbitration cycle.
- Mask clearing: mask[i] clears on any edge where req[i]=0, in every state. A timed-out requester must drop req for at least one cycle before it is eligible again.
- Requests during GRANT/GAP are ignored for arbitration; no preemption.
- A non-owner raising or dropping req during GRANT has no effect on gnt.
- sel holds the last owner index while idle, so the mux output stays stable; sel changes only on the edge that asserts a new grant.
- Simultaneous release and hold-limit on the same edge: release wins, no timeout pulse, no mask set.
- Reset mid-GRANT: gnt drops asynchronously. After reset release, arbitration restarts from ptr=0.

Test Plan:
- Reset then req=3'b010 at cycle 2 -> gnt=3'b010, sel=2'b01 from cycle 3, busy=1; req drops at cycle 6 -> gnt=0 after that edge; with IDLE_GAP=1, busy falls one cycle later.
- req=3'b111 held, each owner drops req for one cycle after a 3-cycle grant (MAX_HOLD=16) -> grant order 0,1,2,0; sel sequence 00,01,10,00; never two gnt bits high.
- MAX_HOLD=4, req[0] held high continuously -> gnt[0] high exactly 4 cycles, one-cycle timeout pulse; no regrant to 0 until req[0] drops for one cycle and rises again.
- MAX_HOLD=4, req[0] held, req[2] high -> after timeout and gap, gnt=3'b100, sel=2'b10.
- IDLE_GAP=0 versus IDLE_GAP=3, back-to-back requesters -> 1 versus 4 cycles from gnt fall to next gnt rise.
- reset_n pulsed low mid-GRANT between clock edges -> gnt, busy and sel go to 0 immediately; first grant after reset follows ptr=0 order.

Source files
------------

// File: rtl/tri_mux_arbiter.sv
// Round-robin arbiter for a shared three-input select mux: one-hot grant plus
// mux select, with a per-grant hold limit and a dead-time gap between owners.
module tri_mux_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    localparam int              HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [1:0]      GAP_LAST = (IDLE_GAP == 0) ? 2'd0 : 2'(IDLE_GAP - 1);

    // Handshake: req is level-held for the whole transaction; the owner ends it
    // by dropping req, and gnt/sel are valid from the edge after arbitration.
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state, state_n;
    logic [1:0]      ptr, ptr_n;
    logic [2:0]      mask, mask_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [1:0]      gap_cnt, gap_n;
    logic [2:0]      gnt_n;
    logic [1:0]      sel_n;
    logic            busy_n, timeout_n;
    logic [2:0]      elig;
    logic [1:0]      win, cand;

    function automatic logic [1:0] wrap_add(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Scan from the farthest position back to ptr so the first eligible in
    // round-robin order is the last one written.
    always_comb begin
        elig = req & ~mask;
        win  = ptr;
        cand = ptr;
        for (int k = 2; k >= 0; k--) begin
            cand = wrap_add(ptr, 2'(k));
            if (elig[cand]) win = cand;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        mask_n    = mask & req;
        hold_n    = hold_cnt;
        gap_n     = gap_cnt;
        gnt_n     = gnt;
        sel_n     = sel;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    gnt_n   = 3'b001 << win;
                    sel_n   = win;
                    ptr_n   = wrap_add(win, 2'd1);
                    hold_n  = HW'(1);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    gnt_n   = 3'b000;
                    gap_n   = 2'd0;
                    state_n = (IDLE_GAP == 0) ? IDLE : GAP;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIM) begin
                    gnt_n       = 3'b000;
                    timeout_n   = 1'b1;
                    mask_n[sel] = 1'b1;
                    gap_n       = 2'd0;
                    state_n     = (IDLE_GAP == 0) ? IDLE : GAP;
                end else if (MAX_HOLD != 0 && hold_cnt != HOLD_LIM) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_n = IDLE;
                else                     gap_n   = gap_cnt + 2'd1;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            mask     <= 3'b000;
            hold_cnt <= '0;
            gap_cnt  <= 2'd0;
            gnt      <= 3'b000;
            sel      <= 2'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            mask     <= mask_n;
            hold_cnt <= hold_n;
            gap_cnt  <= gap_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
            busy     <= busy_n;
            timeout  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_tri_mux_arbiter.sv
// Bench for tri_mux_arbiter: four parameter variants share one request stream,
// each checked every cycle against a transaction-level model.
module tb_tri_mux_arbiter;

    logic       clk;
    logic       reset_n = 1'b0;
    logic [2:0] req = 3'b000;

    logic [2:0] gnt_v [4];
    logic [1:0] sel_v [4];
    logic       busy_v[4];
    logic       to_v  [4];

    int checks = 0;
    int errors = 0;

    function automatic int mh_of(int g);
        return (g == 1) ? 4 : 16;
    endfunction

    function automatic int ig_of(int g);
        return (g == 2) ? 0 : ((g == 3) ? 3 : 1);
    endfunction

    function automatic int oidx(logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tri_mux_arbiter #(.MAX_HOLD(mh_of(g)), .IDLE_GAP(ig_of(g))) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (req),
            .gnt     (gnt_v[g]),
            .sel     (sel_v[g]),
            .busy    (busy_v[g]),
            .timeout (to_v[g])
        );
    end

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Model: who owns the mux, how long it has held it, how many dead cycles
    // remain before arbitration, and which requesters are locked out.
    int         m_owner[4];
    int         m_held [4];
    int         m_wait [4];
    int         m_ptr  [4];
    int         m_last [4];
    bit         m_to   [4];
    logic [2:0] m_blk  [4];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset_n) begin
                m_owner[i] = -1; m_held[i] = 0; m_wait[i] = 0;
                m_ptr[i] = 0; m_last[i] = 0; m_to[i] = 0; m_blk[i] = 3'b000;
            end else begin
                logic [2:0] nb;
                bit found;
                nb = m_blk[i] & req;
                m_to[i] = 0;
                if (m_owner[i] >= 0) begin
                    if (!req[m_owner[i]]) begin
                        m_owner[i] = -1;
                        m_wait[i] = ig_of(i);
                    end else if (mh_of(i) != 0 && m_held[i] >= mh_of(i)) begin
                        m_to[i] = 1;
                        nb[m_owner[i]] = 1'b1;
                        m_owner[i] = -1;
                        m_wait[i] = ig_of(i);
                    end else begin
                        m_held[i]++;
                    end
                end else if (m_wait[i] > 0) begin
                    m_wait[i]--;
                end else begin
                    found = 0;
                    for (int k = 0; k < 3; k++) begin
                        int c;
                        c = (m_ptr[i] + k) % 3;
                        if (!found && req[c] && !m_blk[i][c]) begin
                            found = 1;
                            m_owner[i] = c;
                            m_held[i] = 1;
                            m_last[i] = c;
                            m_ptr[i] = (c + 1) % 3;
                        end
                    end
                end
                m_blk[i] = nb;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk("gnt", i, int'(gnt_v[i]), (m_owner[i] < 0) ? 0 : (1 << m_owner[i]));
            chk("sel", i, int'(sel_v[i]), m_last[i]);
            chk("busy", i, int'(busy_v[i]), (m_owner[i] >= 0 || m_wait[i] > 0) ? 1 : 0);
            chk("timeout", i, int'(to_v[i]), m_to[i] ? 1 : 0);
            chk("onehot", i, ($countones(gnt_v[i]) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int exp_ord[4] = '{0, 1, 2, 0};

    initial begin
        int cnt_g, cnt_t, zc2, zc3;
        bit found, d2, d3;

        // Reset state and a single request from requester 1.
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("rst_gnt", 0, int'(gnt_v[0]), 0);
        chk("rst_sel", 0, int'(sel_v[0]), 0);
        chk("rst_busy", 0, int'(busy_v[0]), 0);
        chk("rst_timeout", 0, int'(to_v[0]), 0);
        req = 3'b010;
        tick();
        chk("s1_gnt", 0, int'(gnt_v[0]), 2);
        chk("s1_sel", 0, int'(sel_v[0]), 1);
        chk("s1_busy", 0, int'(busy_v[0]), 1);
        tick(); tick(); tick();
        req = 3'b000;
        tick();
        chk("s1_rel_gnt", 0, int'(gnt_v[0]), 0);
        chk("s1_rel_busy", 0, int'(busy_v[0]), 1);
        chk("s1_rel_vs_limit_to", 1, int'(to_v[1]), 0);
        chk("s1_rel_vs_limit_gnt", 1, int'(gnt_v[1]), 0);
        tick();
        chk("s1_busy_fall", 0, int'(busy_v[0]), 0);
        repeat (4) tick();

        // All three requesting, each owner releases after a 3-cycle grant.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int t = 0; t < 20 && !found; t++) begin
                tick();
                if (gnt_v[0] != 3'b000) found = 1;
            end
            chk("s2_grant_seen", k, found ? 1 : 0, 1);
            chk("s2_order", k, oidx(gnt_v[0]), exp_ord[k]);
            chk("s2_sel", k, int'(sel_v[0]), exp_ord[k]);
            tick(); tick();
            req = 3'b111 & ~gnt_v[0];
            tick();
            req = 3'b111;
        end
        req = 3'b000;
        repeat (6) tick();

        // Hold limit of 4 on instance 1, then a waiting requester 2.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req = 3'b001;
        cnt_g = 0;
        cnt_t = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (gnt_v[1][0]) cnt_g++;
            if (to_v[1]) cnt_t++;
        end
        chk("s3_hold_cycles", 1, cnt_g, 4);
        chk("s3_timeout_pulses", 1, cnt_t, 1);
        req = 3'b101;
        tick();
        chk("s4_gnt", 1, int'(gnt_v[1]), 4);
        chk("s4_sel", 1, int'(sel_v[1]), 2);
        req = 3'b000;
        repeat (6) tick();
        req = 3'b001;
        tick();
        chk("s3_regrant", 1, int'(gnt_v[1]), 1);

        // Dead time between back-to-back owners: gap 0 versus gap 3.
        req = 3'b000;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req = 3'b011;
        tick();
        chk("s5_first", 2, int'(gnt_v[2]), 1);
        chk("s5_first", 3, int'(gnt_v[3]), 1);
        req = 3'b010;
        zc2 = 0; zc3 = 0; d2 = 0; d3 = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (!d2) begin
                if (gnt_v[2] == 3'b000) zc2++;
                else d2 = 1;
            end
            if (!d3) begin
                if (gnt_v[3] == 3'b000) zc3++;
                else d3 = 1;
            end
        end
        chk("s5_gap0_cycles", 2, zc2, 1);
        chk("s5_gap3_cycles", 3, zc3, 4);
        chk("s5_next", 2, int'(gnt_v[2]), 2);
        chk("s5_next", 3, int'(gnt_v[3]), 2);

        // Asynchronous reset in the middle of a grant.
        req = 3'b000;
        repeat (6) tick();
        req = 3'b010;
        tick();
        chk("s6_pre_gnt", 0, int'(gnt_v[0]), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("s6_async_gnt", 0, int'(gnt_v[0]), 0);
        chk("s6_async_busy", 0, int'(busy_v[0]), 0);
        chk("s6_async_sel", 0, int'(sel_v[0]), 0);
        tick();
        reset_n = 1'b1;
        req = 3'b101;
        tick();
        chk("s6_ptr0_gnt", 0, int'(gnt_v[0]), 1);
        chk("s6_ptr0_sel", 0, int'(sel_v[0]), 0);
        req = 3'b000;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
